alu_cmd_fetch: RTL

Downstream consumer of the 8-entry ALU command FIFO. Pops 3-word command packets (opcode, operand A, operand B) one word at a time, driving `fifo_ren` from `fifo_empty`. Presents each assembled command to the ALU over a valid/ready handshake. Also keeps an issued-command count and an illegal-opcode count for debug.

---
 rtl/alu_cmd_pkg.sv | 23 ++
 rtl/sat_counter.sv | 19 +
 rtl/alu_cmd_fetch.sv | 84 ++++++++
 3 files changed

// File: rtl/alu_cmd_pkg.sv
// Shared definitions for the ALU command fetch block: opcode set, fetch FSM
// states and packet geometry.
package alu_cmd_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_PASS = 3'd5
    } alu_opcode_t;

    localparam int OPC_LEGAL_MAX = 5;

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } fetch_state_t;

    localparam int CMD_WORDS = 3;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_cmd_fetch.sv
// Pops 3-word command packets from the ALU command FIFO and presents each
// assembled command to the ALU over a valid/ready handshake.
module alu_cmd_fetch
    import alu_cmd_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OPC_W  = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              fifo_ren,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [OPC_W-1:0]  alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              busy,
    output logic [7:0]        cmd_count,
    output logic [3:0]        illegal_count
);

    fetch_state_t     state;
    logic [1:0]       idx;
    logic             rd_pend;
    logic [OPC_W-1:0] opc_word;
    logic             opc_legal;
    logic             illegal_inc;

    assign opc_word    = fifo_rd_data[OPC_W-1:0];
    assign opc_legal   = (opc_word <= OPC_W'(OPC_LEGAL_MAX));
    assign illegal_inc = rd_pend && (idx == 2'd0) && !opc_legal;

    // rd_pend gates the next pop so fifo_empty has caught up before we decide again.
    assign fifo_ren  = (state == FETCH) && !fifo_empty && !rd_pend;
    assign alu_valid = (state == ISSUE);
    assign busy      = (state == ISSUE) || (idx != 2'd0) || rd_pend;

    // NOTE: every register here is updated with <= so all of them sample the
    // pre-edge values of each other, exactly like the flops they become.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= FETCH;
            idx        <= 2'd0;
            rd_pend    <= 1'b0;
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            cmd_count  <= 8'd0;
        end else begin
            rd_pend <= fifo_ren;
            if (rd_pend) begin
                if (idx == 2'd0) begin
                    if (opc_legal) begin
                        alu_opcode <= opc_word;
                        idx        <= 2'd1;
                    end
                end else if (idx == 2'd1) begin
                    alu_a <= fifo_rd_data;
                    idx   <= 2'd2;
                end else if (idx == 2'(CMD_WORDS - 1)) begin
                    alu_b <= fifo_rd_data;
                    idx   <= 2'd0;
                    state <= ISSUE;
                end
            end
            if (alu_valid && alu_ready) begin
                cmd_count <= cmd_count + 8'd1;
                state     <= FETCH;
            end
        end
    end

    sat_counter #(
        .WIDTH (4)
    ) u_illegal_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (illegal_inc),
        .count (illegal_count)
    );

endmodule
